// File: rtl/regfile_sb.sv
// Parametrised register file with a per-register pending scoreboard.
// Two combinational read ports, one synchronous write port, reserve/clear hazard tracking.
module regfile_sb #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] ReserveReg,
    output logic              ReserveAck,
    output logic [ADDR_W:0]   PendingCount
);

    localparam int unsigned    DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_next;

    logic we;
    logic set_pend;
    logic cnt_inc;
    logic cnt_dec;

    always_comb begin
        we         = RegWrite && reset_n && !(ZERO_REG && (WriteReg == '0));
        ReserveAck = Reserve && reset_n &&
                     (!pending[ReserveReg] || (we && (WriteReg == ReserveReg)));
        set_pend   = ReserveAck && !(ZERO_REG && (ReserveReg == '0));
        // A clear re-reserved in the same cycle nets to no change in the count.
        cnt_inc    = set_pend && !pending[ReserveReg];
        cnt_dec    = we && pending[WriteReg] && !(set_pend && (ReserveReg == WriteReg));
    end

    always_comb begin
        pending_next = pending;
        if (we)
            pending_next[WriteReg] = 1'b0;
        if (set_pend)
            pending_next[ReserveReg] = 1'b1;
    end

    function automatic logic [WIDTH-1:0] read_data(input logic [ADDR_W-1:0] addr);
        logic [WIDTH-1:0] data;
        if (ZERO_REG && (addr == '0))
            data = '0;
        else if (BYPASS && we && (WriteReg == addr))
            data = WriteData;
        else
            data = regs[addr];
        return data;
    endfunction

    function automatic logic read_busy(input logic [ADDR_W-1:0] addr);
        logic busy;
        if (ZERO_REG && (addr == '0))
            busy = 1'b0;
        else if (BYPASS && we && (WriteReg == addr))
            busy = 1'b0;
        else
            busy = pending[addr];
        return busy;
    endfunction

    always_comb begin
        ReadData1 = read_data(ReadReg1);
        ReadData2 = read_data(ReadReg2);
        Busy1     = read_busy(ReadReg1);
        Busy2     = read_busy(ReadReg2);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            regs         <= '{default: '0};
            pending      <= '0;
            PendingCount <= '0;
        end else begin
            if (we)
                regs[WriteReg] <= WriteData;
            pending <= pending_next;
            if (cnt_inc && !cnt_dec)
                PendingCount <= PendingCount + CNT_ONE;
            else if (cnt_dec && !cnt_inc)
                PendingCount <= PendingCount - CNT_ONE;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an array-based behavioural model.
module tb_regfile_sb;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32;
    localparam bit          ZR     = 1'b1;
    localparam bit          BP     = 1'b1;

    logic              clock;
    logic              reset_n;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [WIDTH-1:0]  WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [WIDTH-1:0]  ReadData1;
    logic [WIDTH-1:0]  ReadData2;
    logic              Busy1;
    logic              Busy2;
    logic              Reserve;
    logic [ADDR_W-1:0] ReserveReg;
    logic              ReserveAck;
    logic [ADDR_W:0]   PendingCount;

    int checks   = 0;
    int failures = 0;

    regfile_sb #(
        .WIDTH   (WIDTH),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZR),
        .BYPASS  (BP)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .RegWrite    (RegWrite),
        .WriteReg    (WriteReg),
        .WriteData   (WriteData),
        .ReadReg1    (ReadReg1),
        .ReadReg2    (ReadReg2),
        .ReadData1   (ReadData1),
        .ReadData2   (ReadData2),
        .Busy1       (Busy1),
        .Busy2       (Busy2),
        .Reserve     (Reserve),
        .ReserveReg  (ReserveReg),
        .ReserveAck  (ReserveAck),
        .PendingCount(PendingCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: plain arrays updated by the architectural rules.
    logic [WIDTH-1:0] m_regs [DEPTH];
    bit               m_pend [DEPTH];
    bit               model_ready = 1'b0;

    function automatic int m_popcount();
        int n = 0;
        for (int i = 0; i < DEPTH; i++)
            n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic bit m_we();
        return RegWrite && reset_n && !(ZR && WriteReg == 0);
    endfunction

    function automatic bit m_ack();
        return Reserve && reset_n && (!m_pend[ReserveReg] || (m_we() && WriteReg == ReserveReg));
    endfunction

    function automatic logic [WIDTH-1:0] m_rdata(input logic [ADDR_W-1:0] a);
        if (ZR && a == 0) return '0;
        if (BP && m_we() && WriteReg == a) return WriteData;
        return m_regs[a];
    endfunction

    function automatic bit m_busy(input logic [ADDR_W-1:0] a);
        if (ZR && a == 0) return 1'b0;
        if (BP && m_we() && WriteReg == a) return 1'b0;
        return m_pend[a];
    endfunction

    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
            model_ready = 1'b1;
        end else if (model_ready) begin
            bit ack;
            bit we;
            ack = m_ack();
            we  = m_we();
            if (we) begin
                m_regs[WriteReg] = WriteData;
                m_pend[WriteReg] = 1'b0;
            end
            if (ack && !(ZR && ReserveReg == 0))
                m_pend[ReserveReg] = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (model_ready) begin
            check("ReadData1",    64'(ReadData1),    64'(m_rdata(ReadReg1)));
            check("ReadData2",    64'(ReadData2),    64'(m_rdata(ReadReg2)));
            check("Busy1",        64'(Busy1),        64'(m_busy(ReadReg1)));
            check("Busy2",        64'(Busy2),        64'(m_busy(ReadReg2)));
            check("ReserveAck",   64'(ReserveAck),   64'(m_ack()));
            check("PendingCount", 64'(PendingCount), 64'(m_popcount()));
        end
    end

    task automatic drive(input logic rst, input logic w, input logic [ADDR_W-1:0] wr,
                         input logic [WIDTH-1:0] wd, input logic [ADDR_W-1:0] r1,
                         input logic [ADDR_W-1:0] r2, input logic res,
                         input logic [ADDR_W-1:0] rr);
        @(posedge clock);
        #1;
        reset_n    = rst;
        RegWrite   = w;
        WriteReg   = wr;
        WriteData  = wd;
        ReadReg1   = r1;
        ReadReg2   = r2;
        Reserve    = res;
        ReserveReg = rr;
        #2;
    endtask

    initial begin
        reset_n    = 1'b0;
        RegWrite   = 1'b0;
        WriteReg   = '0;
        WriteData  = '0;
        ReadReg1   = '0;
        ReadReg2   = '0;
        Reserve    = 1'b0;
        ReserveReg = '0;

        // Reset held for two cycles, then every register reads zero and idle.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int a = 0; a < DEPTH; a++) begin
            drive(1, 0, 0, 0, ADDR_W'(a), ADDR_W'(DEPTH - 1 - a), 0, 0);
            check("lit_reset_rd1", 64'(ReadData1), 64'h0);
            check("lit_reset_busy2", 64'(Busy2), 64'h0);
            check("lit_reset_cnt", 64'(PendingCount), 64'h0);
        end

        // Same-cycle bypass of a write, then the stored value.
        drive(1, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0);
        check("lit_bypass", 64'(ReadData1), 64'hDEADBEEF);
        drive(1, 0, 0, 0, 5, 5, 0, 0);
        check("lit_stored", 64'(ReadData2), 64'hDEADBEEF);

        // Register 0 is hardwired.
        drive(1, 1, 0, 32'h12345678, 0, 0, 0, 0);
        check("lit_r0_write", 64'(ReadData1), 64'h0);
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        check("lit_r0_ack", 64'(ReserveAck), 64'h1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        check("lit_r0_busy", 64'(Busy1), 64'h0);
        check("lit_r0_cnt", 64'(PendingCount), 64'h0);

        // Scoreboard hazard on r7.
        drive(1, 0, 0, 0, 7, 0, 1, 7);
        check("lit_r7_ack", 64'(ReserveAck), 64'h1);
        drive(1, 0, 0, 0, 7, 0, 1, 7);
        check("lit_r7_reack", 64'(ReserveAck), 64'h0);
        check("lit_r7_busy", 64'(Busy1), 64'h1);
        check("lit_r7_cnt", 64'(PendingCount), 64'h1);
        drive(1, 1, 7, 32'hA5, 7, 0, 0, 0);
        check("lit_r7_clr_busy", 64'(Busy1), 64'h0);
        check("lit_r7_clr_data", 64'(ReadData1), 64'hA5);
        drive(1, 0, 0, 0, 7, 0, 0, 0);
        check("lit_r7_cnt0", 64'(PendingCount), 64'h0);

        // Write and reserve of the same register; then reserve r4 while clearing r3.
        drive(1, 0, 0, 0, 3, 0, 1, 3);
        drive(1, 1, 3, 32'h55, 3, 0, 1, 3);
        check("lit_wr_res_ack", 64'(ReserveAck), 64'h1);
        check("lit_wr_res_cnt", 64'(PendingCount), 64'h1);
        drive(1, 0, 0, 0, 3, 0, 0, 0);
        check("lit_wr_res_data", 64'(ReadData1), 64'h55);
        check("lit_wr_res_busy", 64'(Busy1), 64'h1);
        check("lit_wr_res_cnt2", 64'(PendingCount), 64'h1);
        drive(1, 1, 3, 32'h66, 0, 0, 1, 4);
        check("lit_swap_ack", 64'(ReserveAck), 64'h1);
        drive(1, 0, 0, 0, 4, 3, 0, 0);
        check("lit_swap_cnt", 64'(PendingCount), 64'h1);
        check("lit_swap_busy4", 64'(Busy1), 64'h1);
        check("lit_swap_busy3", 64'(Busy2), 64'h0);

        // Reset discards outstanding reservations and the in-flight write.
        drive(1, 1, 4, 32'h77, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 0, 0, 1, 2);
        drive(1, 0, 0, 0, 0, 0, 1, 9);
        drive(1, 0, 0, 0, 1, 9, 0, 0);
        check("lit_three_cnt", 64'(PendingCount), 64'h3);
        check("lit_model_three", 64'(m_popcount()), 64'h3);
        drive(0, 1, 1, 32'hFF, 1, 5, 1, 10);
        check("lit_rst_ack", 64'(ReserveAck), 64'h0);
        check("lit_rst_nobypass", 64'(ReadData1), 64'h0);
        drive(1, 0, 0, 0, 1, 5, 0, 0);
        check("lit_rst_cnt", 64'(PendingCount), 64'h0);
        check("lit_rst_busy", 64'(Busy1), 64'h0);
        check("lit_rst_r5", 64'(ReadData2), 64'h0);

        // Randomized traffic; narrow address range half the time to force collisions.
        for (int n = 0; n < 3000; n++) begin
            logic [ADDR_W-1:0] wr, r1, r2, rr;
            bit narrow;
            narrow = ($urandom_range(0, 1) == 0);
            wr = narrow ? ADDR_W'($urandom_range(0, 5)) : ADDR_W'($urandom);
            r1 = narrow ? ADDR_W'($urandom_range(0, 5)) : ADDR_W'($urandom);
            r2 = narrow ? ADDR_W'($urandom_range(0, 5)) : ADDR_W'($urandom);
            rr = narrow ? ADDR_W'($urandom_range(0, 5)) : ADDR_W'($urandom);
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) == 0), wr, $urandom,
                  r1, r2, ($urandom_range(0, 1) == 0), rr);
        end

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a per-register pending scoreboard, for the pipelined CPU datapath.
- Two combinational read ports and one synchronous write port.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Pending bits let decode reserve a destination register at issue and see read hazards until writeback clears them.
- Replaces the fixed 32x32 register file in the pipelined core.

## Interface
Parameters:
- WIDTH, 32: data width of each register.
- ADDR_W, 5: address width; depth = 2**ADDR_W.
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes and is never pending.
- BYPASS, 1: 1 = a same-cycle write is forwarded to the read ports.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- RegWrite  in  1  write enable.
- WriteReg  in  ADDR_W  write address.
- WriteData  in  WIDTH  write data.
- ReadReg1, ReadReg2  in  ADDR_W  read addresses.
- ReadData1, ReadData2  out  WIDTH  combinational read data.
- Busy1, Busy2  out  1  read register is pending and its data is not yet available.
- Reserve  in  1  request to mark ReserveReg pending.
- ReserveReg  in  ADDR_W  register to reserve.
- ReserveAck  out  1  combinational; the reserve is accepted this cycle.
- PendingCount  out  ADDR_W+1  registered count of pending registers.

## Operation
- State: regs[0..2**ADDR_W-1] (WIDTH bits each), pending[0..2**ADDR_W-1] (1 bit each), PendingCount counter.
- Write:
  - Effective write `we` = RegWrite && reset_n && !(ZERO_REG && WriteReg==0).
  - On an edge with `we`: regs[WriteReg] <= WriteData and pending[WriteReg] <= 0.
  - Writing a non-pending register is legal and is a plain write.
- Read, per port n:
  - If ZERO_REG and ReadRegn==0: ReadDatan = 0.
  - Else if BYPASS and `we` and WriteReg==ReadRegn: ReadDatan = WriteData.
  - Else: ReadDatan = regs[ReadRegn].
- Busyn = pending[ReadRegn], with two exceptions that force Busyn = 0:
  - BYPASS and `we` and WriteReg==ReadRegn (data is forwarded).
  - ZERO_REG and ReadRegn==0.
- Reserve handshake:
  - ReserveAck = Reserve && reset_n && (!pending[ReserveReg] || (`we` && WriteReg==ReserveReg)).
  - An accepted reserve sets pending[ReserveReg] at the edge.
  - With ZERO_REG, reserving register 0 is acked but sets nothing.
  - A rejected reserve has no effect. Decode must hold Reserve and stall; the block does not queue requests.
- Same register written and reserved in one cycle: data is written, and pending ends at 1 (reserve wins).
- PendingCount always equals the popcount of pending after each edge, maintained as a +1/-1/0 counter:
  - +1: accepted reserve of a register that is not pending.
  - -1: write clearing a pending register that is not re-reserved.
  - 0: both at once on the same register, or neither.
  - A reserve of A and a clearing write of B in the same cycle net to 0.
  - Never exceeds 2**ADDR_W (2**ADDR_W-1 when ZERO_REG).
- Reset (reset_n low at an edge):
  - All regs <= 0, all pending <= 0, PendingCount <= 0.
  - Writes and reserves in that cycle are ignored.
  - While reset_n is low: ReserveAck = 0 and bypass is suppressed.
  - Asserting reset with pending registers outstanding discards them.

## Timing
- Outputs after reset: ReadData1/2 = 0, Busy1/2 = 0, ReserveAck = 0, PendingCount = 0.
- Write latency:
  - BYPASS=1: visible on ReadData in the same cycle.
  - BYPASS=0: visible from the cycle after the edge.
- Reserve latency: Busy asserts from the cycle after the accepting edge. PendingCount updates at the same edge.
- Pending-clear latency: Busy drops in the write cycle when BYPASS=1; in the cycle after the edge when BYPASS=0.
- No multi-cycle operations. Every request completes or is rejected in one cycle.
- ReserveAck, ReadData and Busy are combinational from their inputs and the current state. There is no combinational path from ReserveAck back to any input.

## Test plan
1. Reset then read: hold reset_n=0 for 2 cycles, release, read regs 0..31 -> all ReadData=0, Busy=0, PendingCount=0.
2. Write/bypass: write r5=32'hDEADBEEF, ReadReg1=5 in the same cycle.
   - BYPASS=1 -> ReadData1=32'hDEADBEEF in that cycle.
   - BYPASS=0 -> old value (0), then 32'hDEADBEEF the next cycle.
3. Zero register: write r0=32'h1234_5678, then read r0 -> 0. Reserve r0 -> ReserveAck=1, Busy=0, PendingCount=0.
4. Scoreboard hazard:
   - Reserve r7 -> ack, PendingCount=1, Busy1=1 for ReadReg1=7.
   - Reserve r7 again -> ReserveAck=0.
   - Write r7=32'hA5 -> Busy1=0, PendingCount=0.
5. Simultaneous events:
   - r3 pending; write r3=32'h55 and reserve r3 in one cycle -> ack=1, r3 holds 32'h55, still Busy, PendingCount unchanged.
   - Reserve r4 plus clearing write r3 -> PendingCount unchanged.
6. Reset mid-operation: reserve r1, r2, r9 (PendingCount=3), then assert reset_n=0 with RegWrite=1 to r1 -> next cycle all regs 0, PendingCount=0, no Busy.
